dram_cmd_scheduler: RTL and testbench
=====================================

// Module: dram_cmd_scheduler
// PURPOSE
//  Parametrised N-bank command scheduler between per-bank controllers and the DFI command/data-enable bus.
//  - Arbitrates ACT/RD/WR/PRE/REF requests and returns one one-hot grant per cycle.
//  - Enforces inter-bank timing: tRRD, tCCD, tWTR, tRTW.
//  - Drives the DFI command, dfi_wrdata_en and dfi_rddata_en with programmable latencies.
// PARAMETERS
//  NUM_BANKS   8   banks arbitrated; power of 2, 2..16
//  BA_WIDTH    3   = $clog2(NUM_BANKS); dfi_ba width
//  RA_WIDTH    14  row address width
//  CA_WIDTH    11  column address width; must be <= ADDR_WIDTH-1
//  ADDR_WIDTH  14  dfi_addr width; must be >= RA_WIDTH
//  CNT_WIDTH   5   width of each timing counter and each *_m1 input
// PORTS
//  clk           in   1                     clock
//  rst           in   1                     synchronous, active-high reset
//  act_req       in   NUM_BANKS             per-bank ACT request
//  rd_req        in   NUM_BANKS             per-bank RD request
//  wr_req        in   NUM_BANKS             per-bank WR request
//  pre_req       in   NUM_BANKS             per-bank PRE request
//  ref_req       in   NUM_BANKS             per-bank REF request
//  ra            in   NUM_BANKS*RA_WIDTH    per-bank row; bank b owns slice b
//  ca            in   NUM_BANKS*CA_WIDTH    per-bank column; bank b owns slice b
//  act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt  out  NUM_BANKS each  one-hot grants, combinational
//  t_rrd_m1, t_ccd_m1, t_wtr_m1, t_rtw_m1     in   CNT_WIDTH each  timing minus 1, quasi-static
//  dfi_wren_lat, dfi_rden_lat                 in   4 each          command-to-enable latency, 1..15
//  dfi_cke       out  1   clock enable
//  dfi_cs_n      out  1   chip select
//  dfi_ras_n, dfi_cas_n, dfi_we_n             out  1 each          command encoding
//  dfi_ba        out  BA_WIDTH      bank address
//  dfi_addr      out  ADDR_WIDTH    row/column address
//  dfi_odt       out  1             on-die termination
//  dfi_wrdata_en out  1             write data enable
//  dfi_rddata_en out  1             read data enable
// BEHAVIOUR
//  - Reset values: cke=0, cs_n=1, ras_n=cas_n=we_n=1, ba=0, addr=0, odt=0, wrdata_en=0, rddata_en=0.
//  - Reset clears every counter, pipe and the round-robin pointer; a reset mid-burst drops pending enables.
//  - cke goes to 1 on the first cycle after rst deasserts and stays 1.
//  - At most one grant per cycle across all five grant vectors.
//  - A grant is asserted in the same cycle as its request; the DFI command is registered and appears next cycle.
//  - Class priority: REF > RD/WR > ACT > PRE.
//  - RD vs WR tie: pick the type of the last CAS issued (reduces bus turnarounds); after reset, RD.
//  - Within a class: round-robin. Pointer = bank after the last granted bank of any class; reset value 0.
//  - Eligibility (eligibility is a precondition of grant):
//      ACT   needs cnt_rrd==0.
//      RD    needs cnt_ccd==0 and cnt_wtr==0.
//      WR    needs cnt_ccd==0 and cnt_rtw==0.
//      PRE, REF  always eligible.
//  - Counters load on issue and decrement to 0 (saturate at 0):
//      ACT issue  -> cnt_rrd = t_rrd_m1
//      RD issue   -> cnt_ccd = t_ccd_m1 and cnt_rtw = t_rtw_m1
//      WR issue   -> cnt_ccd = t_ccd_m1 and cnt_wtr = t_wtr_m1
//    Net effect: consecutive issues are spaced by exactly t_x cycles.
//  - Command encoding, {ras_n,cas_n,we_n}:
//      ACT  011, addr=ra
//      RD   101, addr={ca,10 zero-filled} (addr[10]=0)
//      WR   100, addr as RD
//      PRE  010, addr[10]=0
//      REF  001, ba=0
//      NOP  111, when there is no grant; ba/addr hold their previous values.
//    cs_n=0 for every command including NOP (after reset).
//  - WR issued at DFI cycle T -> wrdata_en=1 for exactly one cycle at T+dfi_wren_lat.
//  - RD issued at DFI cycle T -> rddata_en=1 for exactly one cycle at T+dfi_rden_lat.
//  - Back-to-back CAS give independent pulses; pipe depth is 16, so no pulse is lost.
//  - A latency change while a pulse is in flight is illegal and its behaviour is undefined.
//  - A bank asserting several request types in one cycle: class priority picks the one granted; the rest wait.
// CONFIGURATION
//  SCHED_ODT_EN defined:
//    - dfi_odt=1 from the cycle wrdata_en asserts through 1 cycle after it deasserts.
//    - Back-to-back windows merge into one.
//  SCHED_ODT_EN undefined: dfi_odt is tied to 0 and no ODT logic exists.
// STRUCTURE
//  Package sched_pkg:
//    - cmd_e enum {NOP,ACT,RD,WR,PRE,REF}
//    - localparam {ras_n,cas_n,we_n} encodings per cmd_e
//    - rr_pick function (one-hot round-robin from mask + pointer)
//  Sub-module dfi_lat_pipe:
//    - 16-deep shift register: pulse in, tap selected by a 4-bit latency, pulse out.
//    - Instanced twice, for wrdata_en and rddata_en.
// TESTING
//  1 Reset release: rst=1 for 3 cycles, then 0 -> cke=1 next cycle; NOP on the bus; all grants 0 with no requests.
//  2 RR fairness: act_req=8'hFF held, t_rrd_m1=1 -> act_gnt order b0,b1..b7,b0; grants 2 cycles apart.
//  3 Priority: same cycle ref_req[2], rd_req[5], act_req[1] -> ref_gnt[2] only; next cycle rd_gnt[5].
//  4 WTR: WR b0 then rd_req[1], t_wtr_m1=3 -> RD issues 4 cycles after WR; wrdata_en at WR+dfi_wren_lat=3.
//  5 Latency: RD,RD,RD back-to-back with t_ccd_m1=0, dfi_rden_lat=5 -> rddata_en high for 3 consecutive cycles.
//  6 Mid-op reset: WR issued, rst at WR+1 -> wrdata_en never asserts and all counters read 0.
//  SCHED_ODT_EN build: single WR, lat 2 -> odt high at WR+2 and WR+3.

Source files
------------

// File: rtl/sched_pkg.sv
// -----------------------------------------------------------------------------
// sched_pkg
// Shared types and helpers for the DRAM command scheduler.
//   cmd_e      : scheduler command classes (NOP, ACT, RD, WR, PRE, REF)
//   ENC_*      : {ras_n, cas_n, we_n} encodings for each command
//   cmd_enc    : maps a cmd_e to its {ras_n, cas_n, we_n} encoding
//   rr_pick    : one-hot round-robin pick from a request mask and a start pointer
// -----------------------------------------------------------------------------
package sched_pkg;

  typedef enum logic [2:0] {
    NOP = 3'd0,
    ACT = 3'd1,
    RD  = 3'd2,
    WR  = 3'd3,
    PRE = 3'd4,
    REF = 3'd5
  } cmd_e;

  localparam logic [2:0] ENC_NOP = 3'b111;
  localparam logic [2:0] ENC_ACT = 3'b011;
  localparam logic [2:0] ENC_RD  = 3'b101;
  localparam logic [2:0] ENC_WR  = 3'b100;
  localparam logic [2:0] ENC_PRE = 3'b010;
  localparam logic [2:0] ENC_REF = 3'b001;

  // Widest supported bank count; narrower callers zero-pad the mask.
  localparam int RR_MAX = 16;

  function automatic logic [2:0] cmd_enc(input cmd_e c);
    logic [2:0] enc;
    case (c)
      ACT:     enc = ENC_ACT;
      RD:      enc = ENC_RD;
      WR:      enc = ENC_WR;
      PRE:     enc = ENC_PRE;
      REF:     enc = ENC_REF;
      default: enc = ENC_NOP;
    endcase
    return enc;
  endfunction

  // Scan upward from ptr (wrapping at 16) and grant the first set mask bit.
  // Zero padding above the real bank count is skipped naturally.
  function automatic logic [RR_MAX-1:0] rr_pick(input logic [RR_MAX-1:0] mask,
                                                input logic [3:0]        ptr);
    logic [RR_MAX-1:0] gnt;
    logic              found;
    logic [3:0]        idx;
    gnt   = {RR_MAX{1'b0}};
    found = 1'b0;
    for (int i = 0; i < RR_MAX; i++) begin
      idx = ptr + 4'(i);
      if (mask[idx] && !found) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end else begin
        gnt = gnt;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/dfi_lat_pipe.sv
// -----------------------------------------------------------------------------
// dfi_lat_pipe
// 16-deep pulse delay line for DFI data enables.
//   clk, rst   : clock, synchronous active-high reset (drops in-flight pulses)
//   pulse_in   : issue strobe, high in the grant cycle (one cycle before the
//                command appears on the DFI bus)
//   lat        : command-to-enable latency in DFI cycles (1..15)
//   pulse_out  : high exactly lat cycles after the command's DFI cycle
// Because pulse_in leads the DFI command by one cycle, stage k holds the pulse
// k cycles after the DFI command cycle, so the tap index equals the latency.
// -----------------------------------------------------------------------------
module dfi_lat_pipe (
  input  logic       clk,
  input  logic       rst,
  input  logic       pulse_in,
  input  logic [3:0] lat,
  output logic       pulse_out
);

  logic [15:0] sr_r;

  // Shift the issue strobe through the delay line.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_r <= 16'h0000;
    end else begin
      sr_r <= {sr_r[14:0], pulse_in};
    end
  end

  assign pulse_out = sr_r[lat];

endmodule

// File: rtl/dram_cmd_scheduler.sv
// -----------------------------------------------------------------------------
// dram_cmd_scheduler
// N-bank command scheduler between per-bank controllers and the DFI bus.
//   Requests : act_req, rd_req, wr_req, pre_req, ref_req (one bit per bank),
//              ra / ca (per-bank row / column slices)
//   Grants   : act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt (combinational,
//              at most one bit set across all five vectors)
//   Timing   : t_rrd_m1, t_ccd_m1, t_wtr_m1, t_rtw_m1 (timing minus one),
//              dfi_wren_lat, dfi_rden_lat (1..15)
//   DFI      : dfi_cke, dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n, dfi_ba,
//              dfi_addr, dfi_odt, dfi_wrdata_en, dfi_rddata_en
// Optional feature macro: SCHED_ODT_EN (drives dfi_odt around write data;
// without it dfi_odt is tied low).
// -----------------------------------------------------------------------------
module dram_cmd_scheduler
  import sched_pkg::*;
#(
  parameter int NUM_BANKS  = 8,
  parameter int BA_WIDTH   = 3,
  parameter int RA_WIDTH   = 14,
  parameter int CA_WIDTH   = 11,
  parameter int ADDR_WIDTH = 14,
  parameter int CNT_WIDTH  = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_BANKS-1:0]          act_req,
  input  logic [NUM_BANKS-1:0]          rd_req,
  input  logic [NUM_BANKS-1:0]          wr_req,
  input  logic [NUM_BANKS-1:0]          pre_req,
  input  logic [NUM_BANKS-1:0]          ref_req,
  input  logic [NUM_BANKS*RA_WIDTH-1:0] ra,
  input  logic [NUM_BANKS*CA_WIDTH-1:0] ca,
  output logic [NUM_BANKS-1:0]          act_gnt,
  output logic [NUM_BANKS-1:0]          rd_gnt,
  output logic [NUM_BANKS-1:0]          wr_gnt,
  output logic [NUM_BANKS-1:0]          pre_gnt,
  output logic [NUM_BANKS-1:0]          ref_gnt,
  input  logic [CNT_WIDTH-1:0]          t_rrd_m1,
  input  logic [CNT_WIDTH-1:0]          t_ccd_m1,
  input  logic [CNT_WIDTH-1:0]          t_wtr_m1,
  input  logic [CNT_WIDTH-1:0]          t_rtw_m1,
  input  logic [3:0]                    dfi_wren_lat,
  input  logic [3:0]                    dfi_rden_lat,
  output logic                          dfi_cke,
  output logic                          dfi_cs_n,
  output logic                          dfi_ras_n,
  output logic                          dfi_cas_n,
  output logic                          dfi_we_n,
  output logic [BA_WIDTH-1:0]           dfi_ba,
  output logic [ADDR_WIDTH-1:0]         dfi_addr,
  output logic                          dfi_odt,
  output logic                          dfi_wrdata_en,
  output logic                          dfi_rddata_en
);

  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};

  logic [CNT_WIDTH-1:0]  cnt_rrd_r, cnt_ccd_r, cnt_wtr_r, cnt_rtw_r;
  logic [BA_WIDTH-1:0]   ptr_r;
  logic                  last_wr_r;
  logic                  rd_ok_s, wr_ok_s, act_ok_s;
  cmd_e                  cmd_s;
  logic [NUM_BANKS-1:0]  mask_s, gnt_s;
  logic [RR_MAX-1:0]     pick_s;
  logic [BA_WIDTH-1:0]   gnt_idx_s;
  logic [RA_WIDTH-1:0]   ra_sel_s;
  logic [CA_WIDTH-1:0]   ca_sel_s;
  logic [ADDR_WIDTH-1:0] cas_addr_s;

  function automatic logic [CNT_WIDTH-1:0] sat_dec(input logic [CNT_WIDTH-1:0] c);
    return (c == CNT_ZERO) ? c : c - CNT_WIDTH'(1);
  endfunction

  assign act_ok_s = (|act_req) && (cnt_rrd_r == CNT_ZERO);
  assign rd_ok_s  = (|rd_req) && (cnt_ccd_r == CNT_ZERO) && (cnt_wtr_r == CNT_ZERO);
  assign wr_ok_s  = (|wr_req) && (cnt_ccd_r == CNT_ZERO) && (cnt_rtw_r == CNT_ZERO);

  // Pick the winning class; RD/WR ties follow the last CAS to avoid turnarounds.
  always_comb begin
    cmd_s  = NOP;
    mask_s = {NUM_BANKS{1'b0}};
    if (|ref_req) begin
      cmd_s  = REF;
      mask_s = ref_req;
    end else if (rd_ok_s && wr_ok_s) begin
      cmd_s  = last_wr_r ? WR : RD;
      mask_s = last_wr_r ? wr_req : rd_req;
    end else if (rd_ok_s) begin
      cmd_s  = RD;
      mask_s = rd_req;
    end else if (wr_ok_s) begin
      cmd_s  = WR;
      mask_s = wr_req;
    end else if (act_ok_s) begin
      cmd_s  = ACT;
      mask_s = act_req;
    end else if (|pre_req) begin
      cmd_s  = PRE;
      mask_s = pre_req;
    end else begin
      cmd_s  = NOP;
      mask_s = {NUM_BANKS{1'b0}};
    end
  end

  assign pick_s = rr_pick(RR_MAX'(mask_s), 4'(ptr_r));
  assign gnt_s  = pick_s[NUM_BANKS-1:0];

  if (NUM_BANKS < RR_MAX) begin : g_pick_pad
    logic unused_pick_s;
    assign unused_pick_s = ^pick_s[RR_MAX-1:NUM_BANKS];
  end

  assign act_gnt = (cmd_s == ACT) ? gnt_s : {NUM_BANKS{1'b0}};
  assign rd_gnt  = (cmd_s == RD)  ? gnt_s : {NUM_BANKS{1'b0}};
  assign wr_gnt  = (cmd_s == WR)  ? gnt_s : {NUM_BANKS{1'b0}};
  assign pre_gnt = (cmd_s == PRE) ? gnt_s : {NUM_BANKS{1'b0}};
  assign ref_gnt = (cmd_s == REF) ? gnt_s : {NUM_BANKS{1'b0}};

  // Encode the one-hot grant as a bank index.
  always_comb begin
    gnt_idx_s = {BA_WIDTH{1'b0}};
    for (int b = 0; b < NUM_BANKS; b++) begin
      gnt_idx_s = gnt_idx_s | (gnt_s[b] ? BA_WIDTH'(b) : {BA_WIDTH{1'b0}});
    end
  end

  assign ra_sel_s = ra[int'(gnt_idx_s)*RA_WIDTH +: RA_WIDTH];
  assign ca_sel_s = ca[int'(gnt_idx_s)*CA_WIDTH +: CA_WIDTH];

  // Column address: low ten bits direct, bit 10 (auto-precharge) held 0,
  // remaining column bits shifted up past it.
  always_comb begin
    cas_addr_s = {ADDR_WIDTH{1'b0}};
    for (int i = 0; i < CA_WIDTH; i++) begin
      if (i < 10) begin
        cas_addr_s[i] = ca_sel_s[i];
      end else begin
        cas_addr_s[i+1] = ca_sel_s[i];
      end
    end
  end

  // Timing counters, round-robin pointer and last-CAS direction.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_rrd_r <= CNT_ZERO;
      cnt_ccd_r <= CNT_ZERO;
      cnt_wtr_r <= CNT_ZERO;
      cnt_rtw_r <= CNT_ZERO;
      ptr_r     <= {BA_WIDTH{1'b0}};
      last_wr_r <= 1'b0;
    end else begin
      cnt_rrd_r <= (cmd_s == ACT) ? t_rrd_m1 : sat_dec(cnt_rrd_r);
      cnt_ccd_r <= (cmd_s == RD || cmd_s == WR) ? t_ccd_m1 : sat_dec(cnt_ccd_r);
      cnt_wtr_r <= (cmd_s == WR) ? t_wtr_m1 : sat_dec(cnt_wtr_r);
      cnt_rtw_r <= (cmd_s == RD) ? t_rtw_m1 : sat_dec(cnt_rtw_r);
      ptr_r     <= (cmd_s != NOP) ? gnt_idx_s + BA_WIDTH'(1) : ptr_r;
      case (cmd_s)
        RD:      last_wr_r <= 1'b0;
        WR:      last_wr_r <= 1'b1;
        default: last_wr_r <= last_wr_r;
      endcase
    end
  end

  // Registered DFI command; NOP keeps ba/addr from the previous command.
  always_ff @(posedge clk) begin
    if (rst) begin
      dfi_cke   <= 1'b0;
      dfi_cs_n  <= 1'b1;
      dfi_ras_n <= 1'b1;
      dfi_cas_n <= 1'b1;
      dfi_we_n  <= 1'b1;
      dfi_ba    <= {BA_WIDTH{1'b0}};
      dfi_addr  <= {ADDR_WIDTH{1'b0}};
    end else begin
      dfi_cke  <= 1'b1;
      dfi_cs_n <= 1'b0;
      {dfi_ras_n, dfi_cas_n, dfi_we_n} <= cmd_enc(cmd_s);
      case (cmd_s)
        ACT: begin
          dfi_ba   <= gnt_idx_s;
          dfi_addr <= ADDR_WIDTH'(ra_sel_s);
        end
        RD, WR: begin
          dfi_ba   <= gnt_idx_s;
          dfi_addr <= cas_addr_s;
        end
        PRE: begin
          dfi_ba   <= gnt_idx_s;
          dfi_addr <= {ADDR_WIDTH{1'b0}};
        end
        REF: begin
          dfi_ba   <= {BA_WIDTH{1'b0}};
          dfi_addr <= dfi_addr;
        end
        default: begin
          dfi_ba   <= dfi_ba;
          dfi_addr <= dfi_addr;
        end
      endcase
    end
  end

  dfi_lat_pipe u_wr_pipe (
    .clk       (clk),
    .rst       (rst),
    .pulse_in  (cmd_s == WR),
    .lat       (dfi_wren_lat),
    .pulse_out (dfi_wrdata_en)
  );

  dfi_lat_pipe u_rd_pipe (
    .clk       (clk),
    .rst       (rst),
    .pulse_in  (cmd_s == RD),
    .lat       (dfi_rden_lat),
    .pulse_out (dfi_rddata_en)
  );

`ifdef SCHED_ODT_EN
  logic wren_d_r;

  // One-cycle echo of write data enable extends ODT past the data beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      wren_d_r <= 1'b0;
    end else begin
      wren_d_r <= dfi_wrdata_en;
    end
  end

  assign dfi_odt = dfi_wrdata_en | wren_d_r;
`else
  assign dfi_odt = 1'b0;
`endif

endmodule

// File: tb/tb_dram_cmd_scheduler.sv
// -----------------------------------------------------------------------------
// tb_dram_cmd_scheduler
// Directed bench for dram_cmd_scheduler (default parameters). Inputs change
// 1 time unit after the rising edge, checks run 1 unit later.
// -----------------------------------------------------------------------------
module tb_dram_cmd_scheduler;
  localparam int NB  = 8;
  localparam int BAW = 3;
  localparam int RAW = 14;
  localparam int CAW = 11;
  localparam int AW  = 14;
  localparam int CW  = 5;

`ifdef SCHED_ODT_EN
  localparam logic ODT_ON = 1'b1;
`else
  localparam logic ODT_ON = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [NB-1:0]    act_req, rd_req, wr_req, pre_req, ref_req;
  logic [NB*RAW-1:0] ra;
  logic [NB*CAW-1:0] ca;
  logic [NB-1:0]    act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt;
  logic [CW-1:0]    t_rrd_m1, t_ccd_m1, t_wtr_m1, t_rtw_m1;
  logic [3:0]       dfi_wren_lat, dfi_rden_lat;
  logic             dfi_cke, dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n;
  logic [BAW-1:0]   dfi_ba;
  logic [AW-1:0]    dfi_addr;
  logic             dfi_odt, dfi_wrdata_en, dfi_rddata_en;

  logic [2:0]       cmd3;
  logic [5*NB-1:0]  all_gnt;
  assign cmd3    = {dfi_ras_n, dfi_cas_n, dfi_we_n};
  assign all_gnt = {act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt};

  int checks   = 0;
  int failures = 0;

  dram_cmd_scheduler #(
    .NUM_BANKS(NB), .BA_WIDTH(BAW), .RA_WIDTH(RAW),
    .CA_WIDTH(CAW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .act_req(act_req), .rd_req(rd_req), .wr_req(wr_req),
    .pre_req(pre_req), .ref_req(ref_req), .ra(ra), .ca(ca),
    .act_gnt(act_gnt), .rd_gnt(rd_gnt), .wr_gnt(wr_gnt),
    .pre_gnt(pre_gnt), .ref_gnt(ref_gnt),
    .t_rrd_m1(t_rrd_m1), .t_ccd_m1(t_ccd_m1), .t_wtr_m1(t_wtr_m1), .t_rtw_m1(t_rtw_m1),
    .dfi_wren_lat(dfi_wren_lat), .dfi_rden_lat(dfi_rden_lat),
    .dfi_cke(dfi_cke), .dfi_cs_n(dfi_cs_n), .dfi_ras_n(dfi_ras_n),
    .dfi_cas_n(dfi_cas_n), .dfi_we_n(dfi_we_n), .dfi_ba(dfi_ba),
    .dfi_addr(dfi_addr), .dfi_odt(dfi_odt),
    .dfi_wrdata_en(dfi_wrdata_en), .dfi_rddata_en(dfi_rddata_en)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    act_req = '0; rd_req = '0; wr_req = '0; pre_req = '0; ref_req = '0;
    t_rrd_m1 = 5'd0; t_ccd_m1 = 5'd0; t_wtr_m1 = 5'd0; t_rtw_m1 = 5'd0;
    dfi_wren_lat = 4'd3; dfi_rden_lat = 4'd5;
    for (int b = 0; b < NB; b++) begin
      ra[b*RAW +: RAW] = RAW'(32'h100 + b);
      ca[b*CAW +: CAW] = CAW'(32'h010 + b);
    end

    // 1: reset values, then release
    repeat (3) tick();
    chk("rst_cke",   dfi_cke,   64'd0);
    chk("rst_cs_n",  dfi_cs_n,  64'd1);
    chk("rst_cmd",   cmd3,      64'b111);
    chk("rst_ba",    dfi_ba,    64'd0);
    chk("rst_addr",  dfi_addr,  64'd0);
    chk("rst_odt",   dfi_odt,   64'd0);
    chk("rst_wren",  dfi_wrdata_en, 64'd0);
    chk("rst_rden",  dfi_rddata_en, 64'd0);
    rst = 1'b0;
    tick();
    chk("rel_cke",   dfi_cke,  64'd1);
    chk("rel_cs_n",  dfi_cs_n, 64'd0);
    chk("rel_nop",   cmd3,     64'b111);
    chk("rel_gnt",   all_gnt,  64'd0);

    // 2: round-robin ACT with tRRD = 2
    t_rrd_m1 = 5'd1; act_req = 8'hFF; #1;
    for (int k = 0; k < 9; k++) begin
      chk("rr_act_gnt", act_gnt, 64'(1 << (k % 8)));
      tick();
      chk("rr_act_cmd",  cmd3,     64'b011);
      chk("rr_act_ba",   dfi_ba,   64'(k % 8));
      chk("rr_act_addr", dfi_addr, 64'(32'h100 + (k % 8)));
      chk("rr_gap",      act_gnt,  64'd0);
      tick();
    end
    act_req = '0;

    // 3: REF beats RD beats ACT
    ref_req = 8'h04; rd_req = 8'h20; act_req = 8'h02; #1;
    chk("pri_ref",   ref_gnt, 64'h04);
    chk("pri_no_rd", rd_gnt,  64'h00);
    chk("pri_no_act", act_gnt, 64'h00);
    tick(); ref_req = '0; #1;
    chk("pri_ref_cmd", cmd3,   64'b001);
    chk("pri_ref_ba",  dfi_ba, 64'd0);
    chk("pri_rd",      rd_gnt, 64'h20);
    chk("pri_rd_no_act", act_gnt, 64'h00);
    tick(); rd_req = '0; act_req = '0; wr_req = 8'h01; t_wtr_m1 = 5'd3; #1;
    chk("pri_rd_cmd",  cmd3,     64'b101);
    chk("pri_rd_ba",   dfi_ba,   64'd5);
    chk("pri_rd_addr", dfi_addr, 64'h0015);

    // 4: tWTR = 4, write latency 3 (this cycle is W)
    chk("wtr_wr_gnt", wr_gnt, 64'h01);
    tick(); wr_req = '0; rd_req = 8'h02; #1;
    chk("wtr_wr_cmd",  cmd3,     64'b100);
    chk("wtr_wr_ba",   dfi_ba,   64'd0);
    chk("wtr_wr_addr", dfi_addr, 64'h0010);
    chk("wtr_hold1",   rd_gnt,   64'h00);
    tick();
    chk("wtr_hold2",   rd_gnt,   64'h00);
    chk("wren_w2",     dfi_wrdata_en, 64'd0);
    tick();
    chk("wtr_hold3",   rd_gnt,   64'h00);
    chk("wren_w3",     dfi_wrdata_en, 64'd0);
    chk("odt_w3",      dfi_odt,  64'd0);
    tick();
    chk("wtr_rd_gnt",  rd_gnt,   64'h02);
    chk("wren_w4",     dfi_wrdata_en, 64'd1);
    chk("odt_w4",      dfi_odt,  64'(ODT_ON));
    chk("rden_w4",     dfi_rddata_en, 64'd0);
    tick(); rd_req = '0; #1;
    chk("wtr_rd_cmd",  cmd3,     64'b101);
    chk("wtr_rd_ba",   dfi_ba,   64'd1);
    chk("wren_w5",     dfi_wrdata_en, 64'd0);
    chk("odt_w5",      dfi_odt,  64'(ODT_ON));
    chk("rden_w5",     dfi_rddata_en, 64'd1);
    tick();
    chk("odt_w6",      dfi_odt,  64'd0);
    chk("rden_w6",     dfi_rddata_en, 64'd0);
    repeat (3) tick();
    chk("rden_w9",     dfi_rddata_en, 64'd0);
    tick();
    chk("rden_w10",    dfi_rddata_en, 64'd1);
    tick();
    chk("rden_w11",    dfi_rddata_en, 64'd0);

    // 5: three back-to-back reads, read latency 5
    rd_req = 8'h0E; #1;
    chk("b2b_gnt0", rd_gnt, 64'h04);
    tick();
    chk("b2b_ba0",  dfi_ba, 64'd2);
    chk("b2b_gnt1", rd_gnt, 64'h08);
    tick();
    chk("b2b_ba1",  dfi_ba, 64'd3);
    chk("b2b_gnt2", rd_gnt, 64'h02);
    tick(); rd_req = '0; #1;
    chk("b2b_ba2",  dfi_ba, 64'd1);
    chk("b2b_idle", all_gnt, 64'd0);
    tick(); tick();
    chk("b2b_rden_pre", dfi_rddata_en, 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("b2b_rden_on", dfi_rddata_en, 64'd1);
    end
    tick();
    chk("b2b_rden_post", dfi_rddata_en, 64'd0);

    // 6: reset one cycle after a WR reaches the bus
    wr_req = 8'h01; #1;
    chk("mrst_wr_gnt", wr_gnt, 64'h01);
    tick(); wr_req = '0; rst = 1'b1; #1;
    chk("mrst_wr_cmd", cmd3, 64'b100);
    tick();
    chk("mrst_cke",  dfi_cke, 64'd0);
    chk("mrst_cmd",  cmd3,    64'b111);
    chk("mrst_ba",   dfi_ba,  64'd0);
    chk("mrst_wren_a", dfi_wrdata_en, 64'd0);
    rst = 1'b0;
    tick(); rd_req = 8'h03; #1;
    chk("mrst_cke1", dfi_cke, 64'd1);
    chk("mrst_rd_gnt", rd_gnt, 64'h01);
    chk("mrst_wren_b", dfi_wrdata_en, 64'd0);
    tick(); rd_req = '0; #1;
    chk("mrst_wren_c", dfi_wrdata_en, 64'd0);
    chk("mrst_rd_cmd", cmd3,   64'b101);
    chk("mrst_rd_ba",  dfi_ba, 64'd0);
    tick();
    chk("mrst_wren_d", dfi_wrdata_en, 64'd0);

    // 7: RD/WR tie follows the last CAS type; ACT beats PRE
    t_wtr_m1 = 5'd0; rd_req = 8'h01; wr_req = 8'h02; #1;
    chk("tie_rd_gnt", rd_gnt, 64'h01);
    chk("tie_rd_nowr", wr_gnt, 64'h00);
    tick(); rd_req = '0; #1;
    chk("tie_wr_gnt", wr_gnt, 64'h02);
    tick(); rd_req = 8'h01; #1;
    chk("tie_wr_cmd", cmd3,   64'b100);
    chk("tie_wr_ba",  dfi_ba, 64'd1);
    chk("tie_wr_again", wr_gnt, 64'h02);
    chk("tie_wr_nord",  rd_gnt, 64'h00);
    tick(); rd_req = '0; wr_req = '0; act_req = 8'h01; pre_req = 8'h10; #1;
    chk("ap_act_gnt", act_gnt, 64'h01);
    chk("ap_no_pre",  pre_gnt, 64'h00);
    tick(); act_req = '0; #1;
    chk("ap_act_cmd", cmd3,    64'b011);
    chk("ap_pre_gnt", pre_gnt, 64'h10);
    tick(); pre_req = '0; #1;
    chk("pre_cmd",    cmd3,    64'b010);
    chk("pre_ba",     dfi_ba,  64'd4);
    chk("pre_a10",    dfi_addr[10], 64'd0);
    tick();
    chk("nop_cmd",    cmd3,    64'b111);
    chk("nop_ba_hold", dfi_ba, 64'd4);
    chk("nop_cs_n",   dfi_cs_n, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
